// File: rtl/i2s_transmitter.sv
// I2S controller-mode transmitter: AXI-Stream words are paired into L/R frames, buffered in a
// small FIFO and serialised on sck/ws/sd. Define I2S_TX_MONO_EN to send each word in both slots.
module i2s_transmitter #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        sck,
  output logic        ws,
  output logic        sd,
  output logic        underflow,
  output logic        framing_err
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [AW:0]      CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             ws_q, ws_d;
  logic [5:0]       pos_q, pos_d;
  logic [63:0]      shift_q, shift_d;
  logic             underflow_q, underflow_d;
  logic             ferr_q, ferr_d;
  logic             tready_q, tready_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [63:0]      mem_q [FIFO_DEPTH];

  logic        accept, push, pop, sck_fall, load;
  logic [63:0] push_data;

  assign accept   = s_axis_tvalid && tready_q;
  assign sck_fall = (div_q == DIV_LAST) && sck_q;
  // The falling edge that moves p from 0 to 1 is where a new frame enters the shifter.
  assign load     = sck_fall && (pos_q == 6'd0);
  assign pop      = load && (cnt_q != '0);

`ifdef I2S_TX_MONO_EN
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  always_comb begin
    push      = accept;
    push_data = {s_axis_tdata, s_axis_tdata};
    ferr_d    = 1'b0;
  end
`else
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_q;

  always_comb begin
    push       = 1'b0;
    ferr_d     = 1'b0;
    hold_vld_d = hold_vld_q;
    push_data  = {hold_q, s_axis_tdata};
    if (accept) begin
      if (!s_axis_tlast) begin
        ferr_d     = hold_vld_q;
        hold_vld_d = 1'b1;
      end else if (hold_vld_q) begin
        push       = 1'b1;
        hold_vld_d = 1'b0;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) hold_vld_q <= 1'b0;
    else                 hold_vld_q <= hold_vld_d;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (accept && !s_axis_tlast) hold_q <= s_axis_tdata;
  end
`endif

  always_comb begin
    div_d       = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    sck_d       = (div_q == DIV_LAST) ? ~sck_q : sck_q;
    pos_d       = pos_q;
    ws_d        = ws_q;
    shift_d     = shift_q;
    underflow_d = load && (cnt_q == '0);
    if (sck_fall) begin
      pos_d   = pos_q + 6'd1;
      ws_d    = pos_d[5];
      shift_d = load ? (pop ? mem_q[rd_q] : '0) : {shift_q[62:0], 1'b0};
    end
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    tready_d = (cnt_d != CNT_FULL);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      div_q       <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      pos_q       <= '0;
      shift_q     <= '0;
      underflow_q <= 1'b0;
      ferr_q      <= 1'b0;
      tready_q    <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      div_q       <= div_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      pos_q       <= pos_d;
      shift_q     <= shift_d;
      underflow_q <= underflow_d;
      ferr_q      <= ferr_d;
      tready_q    <= tready_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign s_axis_tready = tready_q;
  assign sck           = sck_q;
  assign ws            = ws_q;
  assign sd            = shift_q[63];
  assign underflow     = underflow_q;
  assign framing_err   = ferr_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: queued AXI-Stream driver, time-arithmetic reference model of the
// expected I2S stream, and one task per scenario.
module tb_i2s_transmitter;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic        tready, sck, ws, sd, underflow, framing_err;

  int n_cmp = 0;
  int n_bad = 0;
  int gap_pct = 0;
  logic [32:0] tx_q[$];

  // Reference model: frames queued by accepted words, output derived from elapsed clock count.
  int          e;
  logic [63:0] mq[$];
  logic        m_tready, m_under, m_ferr, m_acc, hold_v;
  logic [31:0] hold;
  logic [63:0] cur;
  int          fj;
  logic [5:0]  fp;
  logic        e_sck, e_ws, e_sd;

  assign fj    = e / (2 * CLK_DIV);
  assign fp    = 6'(fj % 64);
  assign e_sck = ((e / CLK_DIV) % 2) == 1;
  assign e_ws  = fp[5];
  assign e_sd  = cur[6'd63 - (fp - 6'd1)];

  i2s_transmitter #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tdata(tdata), .s_axis_tlast(tlast),
    .sck(sck), .ws(ws), .sd(sd), .underflow(underflow), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  initial begin
    e = 0; m_tready = 0; m_under = 0; m_ferr = 0; m_acc = 0; hold_v = 0; hold = '0; cur = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0; mq.delete(); m_tready = 0; m_under = 0; m_ferr = 0; m_acc = 0;
        hold_v = 0; cur = '0;
      end else begin
        e++;
        m_under = 0;
        m_ferr  = 0;
        if (e % (2 * CLK_DIV) == 0 && (e / (2 * CLK_DIV)) % 64 == 1) begin
          if (mq.size() != 0) cur = mq.pop_front();
          else begin cur = '0; m_under = 1; end
        end
        m_acc = tvalid && m_tready;
        if (m_acc) begin
`ifdef I2S_TX_MONO_EN
          mq.push_back({tdata, tdata});
`else
          if (!tlast) begin m_ferr = hold_v; hold = tdata; hold_v = 1; end
          else if (hold_v) begin mq.push_back({hold, tdata}); hold_v = 0; end
          else m_ferr = 1;
`endif
        end
        m_tready = mq.size() < FIFO_DEPTH;
      end
    end
  end

  // AXI-Stream driver: holds each word until the model reports it taken.
  initial begin
    logic [32:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) tvalid = 1'b0;
      else begin
        if (tvalid && m_acc) tvalid = 1'b0;
        if (!tvalid && tx_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
          w = tx_q.pop_front();
          tdata = w[31:0]; tlast = w[32]; tvalid = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    tx_q.delete();
    gap_pct = 0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int first_hi;
    #1 rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({sck, ws, sd, tready, underflow, framing_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 000000", {sck, ws, sd, tready, underflow, framing_err});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (tready !== 1'b0) begin
      n_bad++;
      $display("FAIL tready_at_release: got %b required 0", tready);
    end
    first_hi = -1;
    for (int c = 1; c <= 4 * CLK_DIV; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        n_cmp++;
        if (tready !== 1'b1) begin
          n_bad++;
          $display("FAIL tready_first_edge: got %b required 1", tready);
        end
      end
      if (sck === 1'b1 && first_hi < 0) first_hi = c;
    end
    n_cmp++;
    if (first_hi != CLK_DIV) begin
      n_bad++;
      $display("FAIL first_sck_rise: got clock %0d required %0d", first_hi, CLK_DIV);
    end
  endtask

  task automatic test_basic_stereo();
    int k, bad, t1, t2;
    logic prev;
    logic [63:0] bits, wsv, exp_bits;
    string first;
    do_reset();
    tx_q.push_back({1'b0, 32'hA5A5_0000});
    tx_q.push_back({1'b1, 32'h0F0F_FF00});
`ifdef I2S_TX_MONO_EN
    exp_bits = {32'hA5A5_0000, 32'hA5A5_0000};
`else
    exp_bits = {32'hA5A5_0000, 32'h0F0F_FF00};
`endif
    k = 0; bad = 0; t1 = 0; t2 = 0; prev = 0; bits = '0; wsv = '0; first = "";
    for (int c = 1; c <= CLK_DIV * 2 * 66; c++) begin
      @(negedge clk); #1;
      if ({sck, ws, sd, tready, underflow, framing_err} !== {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr}) begin
        if (bad == 0) first = $sformatf("clk %0d dut=%b model=%b", c, {sck, ws, sd, tready, underflow, framing_err}, {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr});
        bad++;
      end
      if (sck && !prev) begin
        k++;
        if (k == 1) t1 = c;
        if (k == 2) t2 = c;
        if (k <= 64) wsv = {wsv[62:0], ws};
        if (k >= 2 && k <= 65) bits = {bits[62:0], sd};
      end
      prev = sck;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL basic_cycles: %0d cycles differ, required 0; first %s", bad, first);
    end
    n_cmp++;
    if (bits !== exp_bits) begin
      n_bad++;
      $display("FAIL basic_sd_frame: got %h required %h", bits, exp_bits);
    end
    n_cmp++;
    if (wsv !== {32'h0, 32'hFFFF_FFFF}) begin
      n_bad++;
      $display("FAIL basic_ws_pattern: got %h required %h", wsv, {32'h0, 32'hFFFF_FFFF});
    end
    n_cmp++;
    if (t2 - t1 != 2 * CLK_DIV) begin
      n_bad++;
      $display("FAIL sck_period: got %0d required %0d", t2 - t1, 2 * CLK_DIV);
    end
  endtask

  task automatic test_underflow();
    int bad, np, p1, p2, ones;
    string first;
    do_reset();
    bad = 0; np = 0; p1 = 0; p2 = 0; ones = 0; first = "";
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk); #1;
      if ({sck, ws, sd, tready, underflow, framing_err} !== {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr}) begin
        if (bad == 0) first = $sformatf("clk %0d dut=%b model=%b", c, {sck, ws, sd, tready, underflow, framing_err}, {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr});
        bad++;
      end
      if (underflow === 1'b1) begin
        np++;
        if (np == 1) p1 = c;
        if (np == 2) p2 = c;
      end
      if (sd !== 1'b0) ones++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL underflow_cycles: %0d cycles differ, required 0; first %s", bad, first);
    end
    n_cmp++;
    if (np != 3) begin
      n_bad++;
      $display("FAIL underflow_count: got %0d required 3", np);
    end
    n_cmp++;
    if (p1 != 2 * CLK_DIV || p2 - p1 != 128 * CLK_DIV) begin
      n_bad++;
      $display("FAIL underflow_timing: got first %0d spacing %0d required %0d and %0d", p1, p2 - p1, 2 * CLK_DIV, 128 * CLK_DIV);
    end
    n_cmp++;
    if (ones != 0) begin
      n_bad++;
      $display("FAIL underflow_sd_quiet: got %0d high cycles required 0", ones);
    end
  endtask

  task automatic test_backpressure();
    int bad, k, acc, acc_drop, exp_drop;
    logic prev, dropped;
    logic [31:0] w[12];
    logic [63:0] dec[7];
    logic [63:0] expf[7];
    string first;
    do_reset();
    foreach (w[i]) w[i] = $urandom();
    expf[0] = '0;
    for (int i = 1; i < 7; i++) begin
`ifdef I2S_TX_MONO_EN
      expf[i] = {w[i - 1], w[i - 1]};
`else
      expf[i] = {w[2 * i - 2], w[2 * i - 1]};
`endif
    end
`ifdef I2S_TX_MONO_EN
    exp_drop = FIFO_DEPTH;
`else
    exp_drop = 2 * FIFO_DEPTH;
`endif
    foreach (dec[i]) dec[i] = '0;
    bad = 0; k = 0; acc = 0; acc_drop = -1; prev = 0; dropped = 0; first = "";
    for (int c = 1; c <= 3620; c++) begin
      @(negedge clk); #1;
      if ({sck, ws, sd, tready, underflow, framing_err} !== {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr}) begin
        if (bad == 0) first = $sformatf("clk %0d dut=%b model=%b", c, {sck, ws, sd, tready, underflow, framing_err}, {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr});
        bad++;
      end
      if (c > 10 && !tready && !dropped) begin dropped = 1; acc_drop = acc; end
      if (tvalid && tready) acc++;
      if (sck && !prev) begin
        k++;
        if (k >= 2 && (k - 2) / 64 < 7) dec[(k - 2) / 64] = {dec[(k - 2) / 64][62:0], sd};
      end
      prev = sck;
      if (c == 10) for (int i = 0; i < 12; i++) tx_q.push_back({1'(i % 2), w[i]});
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL backpressure_cycles: %0d cycles differ, required 0; first %s", bad, first);
    end
    n_cmp++;
    if (acc_drop != exp_drop) begin
      n_bad++;
      $display("FAIL tready_drop: got %0d words before drop required %0d", acc_drop, exp_drop);
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (dec[i] !== expf[i]) begin
        n_bad++;
        $display("FAIL backpressure_frame%0d: got %h required %h", i, dec[i], expf[i]);
      end
    end
  endtask

  task automatic test_framing();
    int bad, k, nerr, exp_err;
    logic prev;
    logic [63:0] dec[2];
    logic [63:0] expf[2];
    string first;
    do_reset();
    tx_q.push_back({1'b1, 32'h1111_1111});
    tx_q.push_back({1'b0, 32'h2222_2222});
    tx_q.push_back({1'b0, 32'h3333_3333});
    tx_q.push_back({1'b1, 32'h4444_4444});
`ifdef I2S_TX_MONO_EN
    expf[0] = {2{32'h1111_1111}}; expf[1] = {2{32'h2222_2222}}; exp_err = 0;
`else
    expf[0] = {32'h3333_3333, 32'h4444_4444}; expf[1] = '0; exp_err = 2;
`endif
    dec[0] = '0; dec[1] = '0;
    bad = 0; k = 0; nerr = 0; prev = 0; first = "";
    for (int c = 1; c <= 1040; c++) begin
      @(negedge clk); #1;
      if ({sck, ws, sd, tready, underflow, framing_err} !== {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr}) begin
        if (bad == 0) first = $sformatf("clk %0d dut=%b model=%b", c, {sck, ws, sd, tready, underflow, framing_err}, {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr});
        bad++;
      end
      if (framing_err === 1'b1) nerr++;
      if (sck && !prev) begin
        k++;
        if (k >= 2 && k <= 129) dec[(k - 2) / 64] = {dec[(k - 2) / 64][62:0], sd};
      end
      prev = sck;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL framing_cycles: %0d cycles differ, required 0; first %s", bad, first);
    end
    n_cmp++;
    if (nerr != exp_err) begin
      n_bad++;
      $display("FAIL framing_err_count: got %0d required %0d", nerr, exp_err);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (dec[i] !== expf[i]) begin
        n_bad++;
        $display("FAIL framing_frame%0d: got %h required %h", i, dec[i], expf[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad, k, np, ones;
    logic prev, reached;
    string first;
    do_reset();
    tx_q.push_back({1'b0, 32'hFFFF_FFFF});
    tx_q.push_back({1'b1, 32'($urandom())});
    tx_q.push_back({1'b0, 32'($urandom())});
    tx_q.push_back({1'b1, 32'($urandom())});
    bad = 0; k = 0; prev = 0; reached = 0; first = "";
    for (int c = 1; c <= 400 && !reached; c++) begin
      @(negedge clk); #1;
      if ({sck, ws, sd, tready, underflow, framing_err} !== {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr}) begin
        if (bad == 0) first = $sformatf("clk %0d dut=%b model=%b", c, {sck, ws, sd, tready, underflow, framing_err}, {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr});
        bad++;
      end
      if (sck && !prev) k++;
      prev = sck;
      if (k == 21) reached = 1;
    end
    n_cmp++;
    if (!reached || {sck, sd} !== 2'b11) begin
      n_bad++;
      $display("FAIL midframe_pre: got reached=%0d sck,sd=%b required 1 and 11", reached, {sck, sd});
    end
    #2 rst_n = 1'b0;
    tx_q.delete();
    #1;
    n_cmp++;
    if ({sck, ws, sd, tready, underflow, framing_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL midframe_async_reset: got %b required 000000", {sck, ws, sd, tready, underflow, framing_err});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    np = 0; ones = 0;
    for (int c = 1; c <= 128 * CLK_DIV + 4 * CLK_DIV; c++) begin
      @(negedge clk); #1;
      if ({sck, ws, sd, tready, underflow, framing_err} !== {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr}) begin
        if (bad == 0) first = $sformatf("post clk %0d dut=%b model=%b", c, {sck, ws, sd, tready, underflow, framing_err}, {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr});
        bad++;
      end
      if (underflow === 1'b1) np++;
      if (sd !== 1'b0) ones++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL midframe_cycles: %0d cycles differ, required 0; first %s", bad, first);
    end
    n_cmp++;
    if (np != 2 || ones != 0) begin
      n_bad++;
      $display("FAIL midframe_fifo_empty: got %0d underflows %0d sd-high required 2 and 0", np, ones);
    end
  endtask

  task automatic test_random();
    int bad;
    logic want_last, lst;
    string first;
    do_reset();
    gap_pct = 30;
    want_last = 1'b0;
    for (int i = 0; i < 24; i++) begin
      lst = want_last;
      if ($urandom_range(0, 9) == 0) lst = ~lst;
      tx_q.push_back({lst, 32'($urandom())});
      want_last = ~lst;
    end
    bad = 0; first = "";
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk); #1;
      if ({sck, ws, sd, tready, underflow, framing_err} !== {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr}) begin
        if (bad == 0) first = $sformatf("clk %0d dut=%b model=%b", c, {sck, ws, sd, tready, underflow, framing_err}, {e_sck, e_ws, e_sd, m_tready, m_under, m_ferr});
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL random_cycles: %0d cycles differ, required 0; first %s", bad, first);
    end
    n_cmp++;
    if (tx_q.size() != 0 || tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL random_drain: got %0d queued words tvalid=%b required 0 and 0", tx_q.size(), tvalid);
    end
  endtask

`ifdef I2S_TX_MONO_EN
  task automatic test_mono();
    int k, nerr;
    logic prev;
    logic [63:0] bits;
    do_reset();
    tx_q.push_back({1'b0, 32'hDEAD_BE00});
    k = 0; nerr = 0; prev = 0; bits = '0;
    for (int c = 1; c <= CLK_DIV * 2 * 66; c++) begin
      @(negedge clk); #1;
      if (framing_err === 1'b1) nerr++;
      if (sck && !prev) begin
        k++;
        if (k >= 2 && k <= 65) bits = {bits[62:0], sd};
      end
      prev = sck;
    end
    n_cmp++;
    if (bits !== {2{32'hDEAD_BE00}}) begin
      n_bad++;
      $display("FAIL mono_frame: got %h required %h", bits, {2{32'hDEAD_BE00}});
    end
    n_cmp++;
    if (nerr != 0) begin
      n_bad++;
      $display("FAIL mono_framing_err: got %0d pulses required 0", nerr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_stereo();
    test_underflow();
    test_backpressure();
    test_framing();
    test_reset_mid();
    test_random();
`ifdef I2S_TX_MONO_EN
    test_mono();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S controller-mode transmitter. Accepts 32-bit audio words on an AXI-Stream slave, pairs them into left/right frames, buffers them in a small FIFO and serialises them on sck/ws/sd towards a DAC/amplifier.
- Same word format as the microphone receive path: 24-bit sample in tdata[31:8], shifted out as a 32-bit slot. This gives the audio pipeline a playback output.

Parameters:
- CLK_DIV, 4: system clocks per sck half-period; must be >= 2. sck period = 2*CLK_DIV clocks.
- FIFO_DEPTH, 4: number of stereo frames buffered; power of two, >= 2.

Ports:
- s_axis_aclk  in  1  system clock; all logic on the rising edge.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  block can accept a word.
- s_axis_tdata  in  32  audio word; MSB transmitted first.
- s_axis_tlast  in  1  1 = right-channel word (closes a frame); 0 = left-channel word.
- sck  out  1  I2S bit clock.
- ws  out  1  word select; 0 = left slot, 1 = right slot.
- sd  out  1  serial data; changes only on sck falling edges.
- underflow  out  1  one-clock pulse when a frame starts with the FIFO empty.
- framing_err  out  1  one-clock pulse on a tlast protocol violation.

Behaviour:
- Reset (async assert, sync release): sck=0, ws=0, sd=0, s_axis_tready=0, underflow=0, framing_err=0, FIFO empty, left-holding register invalid, frame position p=0, divider=0.
- Handshake:
  - Transfer occurs when tvalid && tready.
  - tready = !fifo_full, registered; it is 1 from the first clock after reset release.
  - tready must not depend combinationally on tvalid.
- Pairing:
  - tlast=0 word: stored in the holding register and marked valid.
  - tlast=0 word while the holding register is already valid: overwrites it and pulses framing_err.
  - tlast=1 word with a valid left held: writes {left, word} into the FIFO and invalidates the holding register.
  - tlast=1 word with no left held: word is dropped and framing_err pulses.
- Clock generation:
  - Divider counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and sck toggles.
  - sck is free-running from reset release.
  - The first rising sck occurs CLK_DIV clocks after release.
- Frame position p (0..63) advances on every sck falling edge (the clock where sck goes 1->0), wrapping 63->0.
  - ws is updated on the same edge: ws = (new p >= 32) ? 1 : 0, so ws leads each slot's MSB by one bit (standard I2S).
- Shift register (64 bit):
  - On the falling edge where p becomes 1: if the FIFO is non-empty, pop one frame and load {L,R}; otherwise load 64'b0 and pulse underflow.
  - sd = shift register MSB after load. Each later falling edge shifts left by 1.
  - sd therefore carries L[31] at p=1 ... L[0] at p=32, R[31] at p=33 ... R[0] at p=0 of the next frame.
- Before the first load, sd=0.
- Simultaneous FIFO push and pop in one clock are both honoured. Occupancy is unchanged, and a full FIFO with a simultaneous pop still refuses the push (tready was 0).
- No mid-frame aborts. Only reset clears state. Reset mid-frame immediately forces all outputs to their reset values.

Optional Feature:
- I2S_TX_MONO_EN
  - Defined: tlast is ignored. Every accepted word is written into the FIFO as {word, word}, the holding register is unused and framing_err is tied 0.
  - Undefined: stereo pairing exactly as above.

Test Plan:
- Basic stereo (CLK_DIV=4): send L=32'hA5A5_0000 (tlast=0) then R=32'h0F0F_FF00 (tlast=1).
  - Sampling sd on sck rising edges must give A5A50000 at p=1..32 then 0F0FFF00 at p=33..64.
  - ws must be 0 for p=0..31 and 1 for p=32..63.
  - sck period must be 8 clocks.
- Underflow: hold tvalid=0 after reset -> underflow pulses once per frame (every 512 clocks with CLK_DIV=4), and sd stays 0.
- Backpressure (FIFO_DEPTH=4): stream 6 frames back-to-back before the first pop -> tready drops after the 4th frame's right word; no data is lost; all 6 frames appear on sd in order.
- Framing errors:
  - Sequence tlast=1 (32'h1111_1111), then L=32'h2222_2222, L=32'h3333_3333, R=32'h4444_4444 -> framing_err pulses twice.
  - The only frame transmitted is {33333333, 44444444}.
- Reset mid-frame: assert s_axis_aresetn=0 at p=20 -> sck, ws and sd go 0 without waiting for a clock edge, tready goes 0 and the FIFO is empty after release.
- Mono build with I2S_TX_MONO_EN defined: send 32'hDEAD_BE00 with tlast=0 -> transmitted in both slots; framing_err never asserts.
